// File: rtl/if_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_if
// Description : Fetch-stage bus bundle: instruction-memory read/resp
//               handshake, control-flow redirect and the valid/ready
//               instruction channel towards decode.
// Revision    : 1.0 - initial release
// ============================================================================
interface if_fetch_if;
  logic [15:0] imem_address;
  logic        imem_read;
  logic        imem_resp;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [15:0] redirect_target;
  logic        id_ready;
  logic        if_valid;
  logic [15:0] if_instruction;
  logic [15:0] if_npc;

  // Fetch stage side
  modport master (
    output imem_address, imem_read, if_valid, if_instruction, if_npc,
    input  imem_resp, imem_rdata, redirect, redirect_target, id_ready
  );

  // Memory / decode / branch-unit side
  modport slave (
    input  imem_address, imem_read, if_valid, if_instruction, if_npc,
    output imem_resp, imem_rdata, redirect, redirect_target, id_ready
  );
endinterface
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch
// Description : LC-3b instruction fetch stage. Holds the PC, reads
//               instruction memory with a read/resp handshake and hands
//               words plus PC+2 to decode through an output register and
//               a one-entry skid register. Redirects flush the buffer and
//               squash any wrong-path response still in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  wire logic  clk,
  input  wire logic  reset_n,
  if_fetch_if.master bus
);

  localparam logic [15:0] RESET_PC_ALIGNED = RESET_PC & 16'hFFFE;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] pc;
  logic [15:0] pc_next;
  logic [15:0] drain_addr;

  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_npc;
  logic        skid_valid;
  logic [15:0] skid_instr;
  logic [15:0] skid_npc;

  logic        transfer;
  logic        space;
  logic        fill;
  logic        fill_to_out;
  logic [15:0] pc_plus2;
  logic [15:0] target;

  assign transfer    = out_valid & bus.id_ready;
  // Room for one more word next edge: skid free and OUT free or draining
  assign space       = ~skid_valid & (~out_valid | transfer);
  // A response is kept only when it answers a live (non-squashed) request
  assign fill        = (state == ST_REQ) & bus.imem_resp & ~bus.redirect;
  assign fill_to_out = ~out_valid | transfer;
  assign pc_plus2    = pc + 16'd2;
  assign target      = bus.redirect_target & 16'hFFFE;

  // State and PC registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      pc    <= RESET_PC_ALIGNED;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Next state and PC: fetch sequencing, redirects and wrong-path draining
  always_comb begin
    state_next = state;
    pc_next    = pc;
    case (state)
      ST_IDLE: begin
        if (bus.redirect) begin
          pc_next    = target;
          state_next = ST_REQ;
        end else if (space) begin
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.redirect) begin
          pc_next = target;
          if (bus.imem_resp) begin
            state_next = space ? ST_REQ : ST_IDLE;
          end else begin
            // Request already on the bus: hold it until memory answers
            state_next = ST_DRAIN;
          end
        end else if (bus.imem_resp) begin
          pc_next    = pc_plus2;
          // Skid stays empty only if this word went straight into OUT
          state_next = fill_to_out ? ST_REQ : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (bus.redirect) begin
          pc_next = target;
        end
        if (bus.imem_resp) begin
          state_next = ST_REQ;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Remember the address on the bus so a drain can keep presenting it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drain_addr <= 16'h0000;
    end else if (state == ST_REQ) begin
      drain_addr <= pc;
    end
  end

  // Output register and skid register: fill, refill and redirect flush
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_instr  <= 16'h0000;
      out_npc    <= 16'h0000;
      skid_valid <= 1'b0;
      skid_instr <= 16'h0000;
      skid_npc   <= 16'h0000;
    end else if (bus.redirect) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (fill) begin
      // Skid is always empty while a request is live
      if (fill_to_out) begin
        out_valid <= 1'b1;
        out_instr <= bus.imem_rdata;
        out_npc   <= pc_plus2;
      end else begin
        skid_valid <= 1'b1;
        skid_instr <= bus.imem_rdata;
        skid_npc   <= pc_plus2;
      end
    end else if (transfer) begin
      if (skid_valid) begin
        out_instr  <= skid_instr;
        out_npc    <= skid_npc;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.imem_read      = (state != ST_IDLE);
  assign bus.imem_address   = (state == ST_DRAIN) ? drain_addr : pc;
  assign bus.if_valid       = out_valid;
  assign bus.if_instruction = out_instr;
  assign bus.if_npc         = out_npc;

endmodule
`default_nettype wire
